// File: rtl/mips_pkg.sv
// mips_pkg: shared memory-op encoding, LSU state encoding and op-class helpers.
// Used by the CPU decoder and by the load/store unit.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } mem_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  function automatic logic is_load(input mem_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_t op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: combinational byte-lane steering for the load/store unit.
// Ports:
//   i_op, i_off          memory op and byte offset (addr[1:0])
//   i_wdata              store data (rt)
//   i_word, i_rt_old     bus read word and current rt (for LWL/LWR merge)
//   o_byteenable         Avalon lane enables
//   o_writedata          lane-replicated store data
//   o_load_data          extended / merged load result
//   o_misalign           access not naturally aligned for its size
module mips_lsu_align
  import mips_pkg::*;
(
  input  mem_op_t     i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  input  logic [31:0] i_rt_old,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [4:0]  w_sh_lo;
  logic [4:0]  w_sh_hi;
  logic [31:0] w_lane;

  // w_sh_hi = 8*(3-o); for a 2-bit offset, 3-o equals ~o.
  assign w_sh_lo = {i_off, 3'b000};
  assign w_sh_hi = {~i_off, 3'b000};
  assign w_lane  = i_word >> w_sh_lo;

  always_comb begin
    o_byteenable = 4'b0000;
    o_writedata  = 32'd0;
    o_load_data  = 32'd0;
    o_misalign   = 1'b0;
    case (i_op)
      OP_LB: begin
        o_byteenable = 4'b0001 << i_off;
        o_load_data  = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      OP_LBU: begin
        o_byteenable = 4'b0001 << i_off;
        o_load_data  = {24'd0, w_lane[7:0]};
      end
      OP_LH: begin
        o_byteenable = 4'b0011 << i_off;
        o_misalign   = i_off[0];
        o_load_data  = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      OP_LHU: begin
        o_byteenable = 4'b0011 << i_off;
        o_misalign   = i_off[0];
        o_load_data  = {16'd0, w_lane[15:0]};
      end
      OP_LW: begin
        o_byteenable = 4'b1111;
        o_misalign   = |i_off;
        o_load_data  = i_word;
      end
      OP_LWL: begin
        o_byteenable = 4'b1111;
        o_load_data  = (i_word << w_sh_hi) | (i_rt_old & ~(32'hFFFF_FFFF << w_sh_hi));
      end
      OP_LWR: begin
        o_byteenable = 4'b1111;
        o_load_data  = w_lane | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_lo));
      end
      OP_SB: begin
        o_byteenable = 4'b0001 << i_off;
        o_writedata  = {4{i_wdata[7:0]}};
      end
      OP_SH: begin
        o_byteenable = 4'b0011 << i_off;
        o_misalign   = i_off[0];
        o_writedata  = {2{i_wdata[15:0]}};
      end
      OP_SW: begin
        o_byteenable = 4'b1111;
        o_misalign   = |i_off;
        o_writedata  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding load/store unit between the execute stage
// and an Avalon-MM data bus.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_*       request from execute (op, addr, wdata, rt_old)
//   resp_valid/resp_data/resp_err   one-cycle completion pulse with result
//   address/read/write/writedata/byteenable/readdata/waitrequest  Avalon-MM master
// Parameter WAIT_LIMIT: consecutive waitrequest cycles before abort (0 = never).
//
// state | meaning
// IDLE  | ready for a request; ops/alignment checked on accept
// BUS   | Avalon strobe held until waitrequest drops or timeout
// RESP  | resp_valid pulse for one cycle
module mips_lsu
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [31:0] LP_LIMIT = 32'(WAIT_LIMIT);

  lsu_state_t  r_state;
  mem_op_t     r_op;
  logic [1:0]  r_off;
  logic [31:0] r_rt_old;
  logic [31:0] r_wait_cnt;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  mem_op_t     w_op;
  logic [1:0]  w_off;
  logic [3:0]  w_byteenable;
  logic [31:0] w_writedata;
  logic [31:0] w_load_data;
  logic        w_misalign;
  logic        w_illegal;
  logic        w_timeout;

  // One aligner serves both directions: in IDLE it sees the incoming request
  // (checks and lane setup on accept), otherwise the latched request.
  assign w_op  = (r_state == LSU_IDLE) ? mem_op_t'(req_op) : r_op;
  assign w_off = (r_state == LSU_IDLE) ? req_addr[1:0] : r_off;

  mips_lsu_align u_align (
    .i_op         (w_op),
    .i_off        (w_off),
    .i_wdata      (req_wdata),
    .i_word       (readdata),
    .i_rt_old     (r_rt_old),
    .o_byteenable (w_byteenable),
    .o_writedata  (w_writedata),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  assign w_illegal = !(is_load(w_op) || is_store(w_op));
  // Counter holds the number of waitrequest cycles already seen in this access.
  assign w_timeout = (LP_LIMIT != 32'd0) && (r_wait_cnt >= (LP_LIMIT - 32'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LSU_IDLE;
      r_op         <= OP_LB;
      r_off        <= 2'd0;
      r_rt_old     <= 32'd0;
      r_wait_cnt   <= 32'd0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= 32'd0;
      r_writedata  <= 32'd0;
      r_byteenable <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_op     <= mem_op_t'(req_op);
            r_off    <= req_addr[1:0];
            r_rt_old <= req_rt_old;
            if (w_illegal || w_misalign) begin
              r_state      <= LSU_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'd0;
            end else begin
              r_state      <= LSU_BUS;
              r_wait_cnt   <= 32'd0;
              r_read       <= is_load(w_op);
              r_write      <= is_store(w_op);
              r_address    <= {req_addr[31:2], 2'b00};
              r_byteenable <= w_byteenable;
              r_writedata  <= w_writedata;
            end
          end
        end
        LSU_BUS: begin
          if (!waitrequest || w_timeout) begin
            r_state      <= LSU_RESP;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= 32'd0;
            r_byteenable <= 4'd0;
            r_writedata  <= 32'd0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= waitrequest;
            r_resp_data  <= (r_read && !waitrequest) ? w_load_data : 32'd0;
          end else if (r_wait_cnt != 32'hFFFF_FFFF) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        LSU_RESP: begin
          r_state      <= LSU_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= 32'd0;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == LSU_IDLE);
  assign read       = r_read;
  assign write      = r_write;
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign byteenable = r_byteenable;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed-vector bench for mips_lsu. Two instances share the
// request/bus inputs: dut0 without timeout, dut4 with WAIT_LIMIT=4.
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        req_ready, resp_valid, resp_err, read, write;
  logic [31:0] resp_data, address, writedata;
  logic [3:0]  byteenable;

  logic        req_ready_4, resp_valid_4, resp_err_4, read_4, write_4;
  logic [31:0] resp_data_4, address_4, writedata_4;
  logic [3:0]  byteenable_4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_lsu dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  mips_lsu #(.WAIT_LIMIT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_4), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid_4), .resp_data(resp_data_4), .resp_err(resp_err_4),
    .address(address_4), .read(read_4), .write(write_4), .waitrequest(waitrequest),
    .writedata(writedata_4), .byteenable(byteenable_4), .readdata(readdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rt_old);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wdata;
    req_rt_old = rt_old;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] rt_old,
                          input logic [3:0] exp_be, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
    readdata    = word;
    waitrequest = 1'b0;
    issue(op, addr, 32'h0, rt_old);
    chk({tag, ".read"},  {31'd0, read}, 32'd1);
    chk({tag, ".write"}, {31'd0, write}, 32'd0);
    chk({tag, ".addr"},  address, exp_addr);
    chk({tag, ".be"},    {28'd0, byteenable}, {28'd0, exp_be});
    chk({tag, ".rvld0"}, {31'd0, resp_valid}, 32'd0);
    tick();
    chk({tag, ".rvld"},  {31'd0, resp_valid}, 32'd1);
    chk({tag, ".rerr"},  {31'd0, resp_err}, 32'd0);
    chk({tag, ".rdata"}, resp_data, exp_data);
    chk({tag, ".rdoff"}, {31'd0, read}, 32'd0);
    tick();
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".rvld1"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic run_err(input string tag, input logic [3:0] op, input logic [31:0] addr);
    waitrequest = 1'b0;
    issue(op, addr, 32'h1234_5678, 32'h0);
    chk({tag, ".read"},  {31'd0, read}, 32'd0);
    chk({tag, ".write"}, {31'd0, write}, 32'd0);
    chk({tag, ".rvld"},  {31'd0, resp_valid}, 32'd1);
    chk({tag, ".rerr"},  {31'd0, resp_err}, 32'd1);
    chk({tag, ".rdata"}, resp_data, 32'd0);
    tick();
    chk({tag, ".rvld1"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wd);
    waitrequest = (waits > 0);
    issue(op, addr, wdata, 32'h0);
    for (int i = 1; i <= waits + 1; i++) begin
      if (i == waits + 1) waitrequest = 1'b0;
      chk($sformatf("%s.write%0d", tag, i), {31'd0, write}, 32'd1);
      chk($sformatf("%s.read%0d", tag, i),  {31'd0, read}, 32'd0);
      chk($sformatf("%s.addr%0d", tag, i),  address, exp_addr);
      chk($sformatf("%s.be%0d", tag, i),    {28'd0, byteenable}, {28'd0, exp_be});
      chk($sformatf("%s.wd%0d", tag, i),    writedata, exp_wd);
      chk($sformatf("%s.rvld%0d", tag, i),  {31'd0, resp_valid}, 32'd0);
      tick();
    end
    chk({tag, ".rvld"},  {31'd0, resp_valid}, 32'd1);
    chk({tag, ".rerr"},  {31'd0, resp_err}, 32'd0);
    chk({tag, ".rdata"}, resp_data, 32'd0);
    chk({tag, ".wroff"}, {31'd0, write}, 32'd0);
    tick();
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 4'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_rt_old  = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    chk("rst.read",  {31'd0, read}, 32'd0);
    chk("rst.write", {31'd0, write}, 32'd0);
    chk("rst.addr",  address, 32'd0);
    chk("rst.wd",    writedata, 32'd0);
    chk("rst.be",    {28'd0, byteenable}, 32'd0);
    chk("rst.rvld",  {31'd0, resp_valid}, 32'd0);
    chk("rst.rdata", resp_data, 32'd0);
    chk("rst.rerr",  {31'd0, resp_err}, 32'd0);

    run_load("lw",     4'd4, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         4'b1111, 32'h0000_1000, 32'hDEAD_BEEF);
    run_load("lb3",    4'd0, 32'h0000_1003, 32'h80FF_1234, 32'h0,         4'b1000, 32'h0000_1000, 32'hFFFF_FF80);
    run_load("lbu3",   4'd1, 32'h0000_1003, 32'h80FF_1234, 32'h0,         4'b1000, 32'h0000_1000, 32'h0000_0080);
    run_load("lb1",    4'd0, 32'h0000_1001, 32'h80FF_1234, 32'h0,         4'b0010, 32'h0000_1000, 32'h0000_0012);
    run_load("lh2",    4'd2, 32'h0000_1002, 32'h80FF_1234, 32'h0,         4'b1100, 32'h0000_1000, 32'hFFFF_80FF);
    run_load("lhu2",   4'd3, 32'h0000_1002, 32'h80FF_1234, 32'h0,         4'b1100, 32'h0000_1000, 32'h0000_80FF);
    run_load("lh0",    4'd2, 32'h0000_1004, 32'h1234_8765, 32'h0,         4'b0011, 32'h0000_1004, 32'hFFFF_8765);
    run_load("lwl1",   4'd5, 32'h0000_1001, 32'h4433_2211, 32'hAABB_CCDD, 4'b1111, 32'h0000_1000, 32'h2211_CCDD);
    run_load("lwr1",   4'd6, 32'h0000_1001, 32'h4433_2211, 32'hAABB_CCDD, 4'b1111, 32'h0000_1000, 32'hAA44_3322);
    run_load("lwl0",   4'd5, 32'h0000_1000, 32'h4433_2211, 32'hAABB_CCDD, 4'b1111, 32'h0000_1000, 32'h11BB_CCDD);
    run_load("lwl3",   4'd5, 32'h0000_1003, 32'h4433_2211, 32'hAABB_CCDD, 4'b1111, 32'h0000_1000, 32'h4433_2211);
    run_load("lwr3",   4'd6, 32'h0000_1003, 32'h4433_2211, 32'hAABB_CCDD, 4'b1111, 32'h0000_1000, 32'hAABB_CC44);

    run_store("sh_wait", 4'd9,  32'h0000_2002, 32'h0000_ABCD, 3, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD);
    run_store("sb1",     4'd8,  32'h0000_3001, 32'h1234_56A5, 0, 4'b0010, 32'h0000_3000, 32'hA5A5_A5A5);
    run_store("sw",      4'd10, 32'h0000_3004, 32'h0BAD_F00D, 0, 4'b1111, 32'h0000_3004, 32'h0BAD_F00D);

    run_err("lw_mis",  4'd4,  32'h0000_1001);
    run_err("sh_mis",  4'd9,  32'h0000_2003);
    run_err("lh_mis",  4'd2,  32'h0000_2001);
    run_err("sw_mis",  4'd10, 32'h0000_2002);
    run_err("illegal", 4'd7,  32'h0000_2000);

    // Timeout on dut4; dut0 (no limit) keeps waiting.
    waitrequest = 1'b1;
    readdata    = 32'h5555_AAAA;
    issue(4'd4, 32'h0000_4000, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to.read4_%0d", i), {31'd0, read_4}, 32'd1);
      chk($sformatf("to.rvld4_%0d", i), {31'd0, resp_valid_4}, 32'd0);
      tick();
    end
    chk("to.read4_off", {31'd0, read_4}, 32'd0);
    chk("to.rvld4",     {31'd0, resp_valid_4}, 32'd1);
    chk("to.rerr4",     {31'd0, resp_err_4}, 32'd1);
    chk("to.rdata4",    resp_data_4, 32'd0);
    chk("to.read0",     {31'd0, read}, 32'd1);
    chk("to.rvld0",     {31'd0, resp_valid}, 32'd0);
    tick();
    chk("to.rvld4_1",   {31'd0, resp_valid_4}, 32'd0);
    chk("to.ready4",    {31'd0, req_ready_4}, 32'd1);
    chk("to.read0_1",   {31'd0, read}, 32'd1);
    chk("to.addr0",     address, 32'h0000_4000);

    // Reset while dut0 is mid-wait: strobe drops, no response ever follows.
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    waitrequest = 1'b0;
    chk("rstbus.read",  {31'd0, read}, 32'd0);
    chk("rstbus.rvld",  {31'd0, resp_valid}, 32'd0);
    chk("rstbus.ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstbus.rvld_%0d", i), {31'd0, resp_valid}, 32'd0);
      chk($sformatf("rstbus.read_%0d", i), {31'd0, read}, 32'd0);
    end

    // Back-to-back sanity after reset.
    run_load("lw_post", 4'd4, 32'h0000_5008, 32'hCAFE_0001, 32'h0, 4'b1111, 32'h0000_5008, 32'hCAFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
